// File: rtl/instr_mem_loader_if.sv
// Loader-side bundle: start/count request, byte stream in,
// instruction-memory write port and status out.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic [CNT_W-1:0]  WordCount;
  logic [7:0]        InData;
  logic              InValid;
  logic              InReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [23:0]       WrData;
  logic              CpuHold;
  logic              LoadDone;
  logic              LoadError;
  logic [7:0]        Checksum;

  modport master (
    output Start, WordCount, InData, InValid,
    input  InReady, WrEn, WrAddr, WrData,
    input  CpuHold, LoadDone, LoadError, Checksum
  );

  modport slave (
    input  Start, WordCount, InData, InValid,
    output InReady, WrEn, WrAddr, WrData,
    output CpuHold, LoadDone, LoadError, Checksum
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: packs a byte stream into 24-bit words and writes
// them to instruction memory while holding the CPU.
module instr_mem_loader #(
  parameter int              ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              ADDR_STEP = 4,
  parameter int              MAX_WORDS = 256,
  parameter int              CNT_W     = 16
) (
  input logic Clock,
  input logic Reset,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, RECV, WRITE, DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE_C =
    CNT_W'(1);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(ADDR_STEP);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  remain;
  logic [1:0]        idx;
  logic [15:0]       shift;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       word;
  logic              hold;
  logic              done;
  logic              err;
  logic [7:0]        csum;

  logic cnt_zero;
  logic cnt_ok;
  logic take;
  logic last_byte;

  assign cnt_zero  = bus.WordCount == '0;
  assign cnt_ok    = !cnt_zero &&
                     bus.WordCount <= MAX_C;
  assign take      = state == RECV && bus.InValid;
  assign last_byte = take && idx == 2'd2;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.Start && cnt_zero)
          state_nx = DONE;
        else if (bus.Start && cnt_ok)
          state_nx = RECV;
      end
      RECV: begin
        if (last_byte) state_nx = WRITE;
      end
      WRITE: begin
        if (remain == ONE_C) state_nx = DONE;
        else                 state_nx = RECV;
      end
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      remain <= '0;
      idx    <= '0;
      shift  <= '0;
      addr   <= BASE_ADDR;
      word   <= '0;
      hold   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      csum   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            done <= cnt_zero;
            err  <= !cnt_zero && !cnt_ok;
            if (cnt_zero) csum <= '0;
            if (cnt_ok) begin
              remain <= bus.WordCount;
              addr   <= BASE_ADDR;
              idx    <= '0;
              csum   <= '0;
              hold   <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take) begin
            csum  <= csum ^ bus.InData;
            shift <= {shift[7:0], bus.InData};
            if (idx == 2'd2) begin
              idx  <= '0;
              word <= {shift, bus.InData};
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        WRITE: begin
          addr   <= addr + STEP;
          remain <= remain - ONE_C;
          // hold drops together with entering DONE
          if (remain == ONE_C) begin
            hold <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign bus.InReady   = state == RECV;
  assign bus.WrEn      = state == WRITE;
  assign bus.WrAddr    = addr;
  assign bus.WrData    = word;
  assign bus.CpuHold   = hold;
  assign bus.LoadDone  = done;
  assign bus.LoadError = err;
  assign bus.Checksum  = csum;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench: two loaders (base 0 and base FFFFFC) share one stimulus
// stream; writes are scored against a word/address model.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  in_data;
  logic        in_valid;

  always #5 clk = ~clk;

  instr_mem_loader_if ifa ();
  instr_mem_loader_if ifw ();

  assign ifa.Start     = start;
  assign ifa.WordCount = word_count;
  assign ifa.InData    = in_data;
  assign ifa.InValid   = in_valid;
  assign ifw.Start     = start;
  assign ifw.WordCount = word_count;
  assign ifw.InData    = in_data;
  assign ifw.InValid   = in_valid;

  instr_mem_loader #(.BASE_ADDR(24'h000000)) dut_a (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifa)
  );

  instr_mem_loader #(.BASE_ADDR(24'hFFFFFC)) dut_w (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifw)
  );

  typedef struct {
    logic [23:0] addr;
    logic [23:0] data;
    int          at;
  } wr_t;

  typedef struct {
    int cnt;
    int gmin;
    int gmax;
    bit poke;
    bit exp_err;
    bit exp_done;
    bit exp_hold;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_at = 0;
  int   bad_hold = 0;
  bit   hold_seen = 0;
  logic done_prev = 1'b0;
  wr_t  got_a[$];
  wr_t  got_w[$];
  logic [7:0] stream[$];
  vec_t tbl[8];

  always @(negedge clk) begin
    cyc++;
    if (ifa.WrEn)
      got_a.push_back('{ifa.WrAddr, ifa.WrData, cyc});
    if (ifw.WrEn)
      got_w.push_back('{ifw.WrAddr, ifw.WrData, cyc});
    if (ifa.CpuHold) hold_seen = 1;
    if (ifa.CpuHold && !ifa.InReady && !ifa.WrEn)
      bad_hold++;
    if (ifa.LoadDone && !done_prev) done_at = cyc;
    done_prev = ifa.LoadDone;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int c);
    start = 1'b1;
    word_count = 16'(c);
    tick();
    start = 1'b0;
    word_count = 16'd0;
  endtask

  task automatic send(input int n, input int gmin,
                      input int gmax, input bit poke);
    int i = 0;
    int gap = 0;
    int budget = 20000;
    while (i < n && budget > 0) begin
      budget--;
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data = stream[i];
      end
      start = poke && i == 4;
      word_count = 16'd0;
      @(negedge clk);
      if (in_valid && ifa.InReady) begin
        i++;
        gap = $urandom_range(gmax, gmin);
      end
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("send_bytes", i, n);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_inready"}, ifa.InReady, 0);
    chk({tag, "_wren"}, ifa.WrEn, 0);
    chk({tag, "_hold"}, ifa.CpuHold, 0);
    chk({tag, "_addr"}, ifa.WrAddr, 0);
    chk({tag, "_addr_w"}, ifw.WrAddr, 32'hFFFFFC);
    chk({tag, "_data"}, ifa.WrData, 0);
    chk({tag, "_done"}, ifa.LoadDone, 0);
    chk({tag, "_err"}, ifa.LoadError, 0);
    chk({tag, "_csum"}, ifa.Checksum, 0);
  endtask

  task automatic check_load(input vec_t v, input bit keep);
    logic [7:0]  x;
    logic [23:0] w;
    logic [23:0] ea;
    int n;
    bit acc;
    acc = v.cnt > 0 && v.cnt <= 256;
    if (!keep) begin
      stream.delete();
      if (acc)
        for (int j = 0; j < 3 * v.cnt; j++)
          stream.push_back(8'($urandom));
    end
    x = 8'h00;
    foreach (stream[j]) x ^= stream[j];
    got_a.delete();
    got_w.delete();
    hold_seen = 0;
    bad_hold = 0;
    pulse_start(v.cnt);
    @(negedge clk);
    chk("k1_hold", ifa.CpuHold, v.exp_hold);
    chk("k1_ready", ifa.InReady, acc);
    chk("k1_err", ifa.LoadError, v.exp_err);
    chk("k1_done", ifa.LoadDone, v.cnt == 0);
    tick();
    if (acc) begin
      chk("k1_csum", ifa.Checksum, 0);
      send(3 * v.cnt, v.gmin, v.gmax, v.poke);
      n = 0;
      while (!ifa.LoadDone && n < 12) begin
        @(negedge clk);
        n++;
      end
      tick();
      chk("done_seen", ifa.LoadDone, 1);
      chk("nwr_a", got_a.size(), v.cnt);
      chk("nwr_w", got_w.size(), v.cnt);
      if (got_a.size() == v.cnt &&
          got_w.size() == v.cnt) begin
        for (int j = 0; j < v.cnt; j++) begin
          w = {stream[3*j], stream[3*j+1], stream[3*j+2]};
          ea = 24'(4 * j);
          chk("wr_addr_a", got_a[j].addr, ea);
          chk("wr_data_a", got_a[j].data, w);
          chk("wr_addr_w", got_w[j].addr,
              24'(32'hFFFFFC + 4 * j));
          chk("wr_data_w", got_w[j].data, w);
          if (j > 0 && v.gmax == 0)
            chk("stride4", got_a[j].at - got_a[j-1].at, 4);
        end
        chk("done_lag", done_at - got_a[v.cnt-1].at, 1);
        chk("data_hold", ifa.WrData, w);
      end
      chk("csum", ifa.Checksum, x);
      chk("csum_w", ifw.Checksum, x);
      chk("ready_gap", bad_hold, 0);
    end else begin
      repeat (4) tick();
      chk("nwr_none", got_a.size(), 0);
    end
    chk("end_hold", ifa.CpuHold, 0);
    chk("hold_seen", hold_seen, v.exp_hold);
    chk("end_done", ifa.LoadDone, v.exp_done);
    chk("end_err", ifa.LoadError, v.exp_err);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    start = 1'b0;
    word_count = 16'd0;
    in_data = 8'h00;
    in_valid = 1'b0;
    tbl[0] = '{1,   0, 0, 0, 0, 1, 1};
    tbl[1] = '{0,   0, 0, 0, 0, 1, 0};
    tbl[2] = '{257, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{1,   0, 0, 0, 0, 1, 1};
    tbl[4] = '{3,   0, 3, 1, 0, 1, 1};
    tbl[5] = '{65535, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{256, 0, 0, 0, 0, 1, 1};
    tbl[7] = '{5,   1, 4, 0, 0, 1, 1};
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    tick();

    // directed packing of 12 34 56 AB CD EF
    for (int g = 0; g < 2; g++) begin
      stream = '{8'h12, 8'h34, 8'h56,
                 8'hAB, 8'hCD, 8'hEF};
      v = '{2, 2 * g, 2 * g, 0, 0, 1, 1};
      check_load(v, 1);
      if (got_a.size() == 2) begin
        chk("fix_w0", got_a[0].data, 24'h123456);
        chk("fix_w1", got_a[1].data, 24'hABCDEF);
        chk("fix_a1", got_a[1].addr, 24'h000004);
        chk("fix_wrap", got_w[1].addr, 24'h000000);
      end
      chk("fix_csum", ifa.Checksum, 8'hF9);
    end

    foreach (tbl[t]) check_load(tbl[t], 0);

    // abort after 4 of 6 bytes
    stream = '{8'h01, 8'h02, 8'h03,
               8'h04, 8'h05, 8'h06};
    got_a.delete();
    pulse_start(2);
    tick();
    send(4, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_nwr", got_a.size(), 1);
    if (got_a.size() == 1)
      chk("abort_w0", got_a[0].data, 24'h010203);
    check_reset_vals("abort");
    tick();
    check_load(tbl[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
